// File: rtl/xmpl_dsp_pkg.sv
// ----------------------------------------------------------------------------
// xmpl_dsp_pkg
// Shared definitions for the xmpl_dsp_core input path.
//   XMPL_SMP_W     : sample width the filter consumes
//   XMPL_SAT_IN_W  : width saturation inputs are sign-extended to
//   sat_res_t      : {clamped flag, saturated sample}
//   sat_to_w()     : clamp a signed value into XMPL_SMP_W bits
// ----------------------------------------------------------------------------
package xmpl_dsp_pkg;

    localparam int XMPL_SMP_W    = 12;
    localparam int XMPL_SAT_IN_W = 32;
    localparam int XMPL_SMP_MAX  = (1 << (XMPL_SMP_W - 1)) - 1;
    localparam int XMPL_SMP_MIN  = -(1 << (XMPL_SMP_W - 1));

    typedef struct packed {
        logic                  clamped;
        logic [XMPL_SMP_W-1:0] value;
    } sat_res_t;

    // Callers sign-extend their sample to XMPL_SAT_IN_W bits first, so a
    // single signed compare against the two limits covers any input width.
    function automatic sat_res_t sat_to_w(input logic signed [XMPL_SAT_IN_W-1:0] din);
        sat_res_t res;
        if (din > XMPL_SMP_MAX) begin
            res.clamped = 1'b1;
            res.value   = XMPL_SMP_W'(XMPL_SMP_MAX);
        end else if (din < XMPL_SMP_MIN) begin
            res.clamped = 1'b1;
            res.value   = XMPL_SMP_W'(XMPL_SMP_MIN);
        end else begin
            res.clamped = 1'b0;
            res.value   = din[XMPL_SMP_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/xmpl_sync_fifo.sv
// ----------------------------------------------------------------------------
// xmpl_sync_fifo
// Single-clock FIFO with registered occupancy count. The head entry is
// presented combinationally on rdata; there is no write-to-read bypass, so a
// word pushed in one cycle is visible at the head from the next cycle.
//   clk    in   clock
//   rst_n  in   asynchronous reset, active low
//   flush  in   synchronous clear of pointers and count
//   push   in   write wdata (ignored when full)
//   pop    in   advance head (ignored when empty)
//   wdata  in   WIDTH  write data
//   rdata  out  WIDTH  current head entry
//   count  out  occupancy, 0..DEPTH
//   empty  out  count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module xmpl_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array is not reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xmpl_flt_in.sv
// ----------------------------------------------------------------------------
// xmpl_flt_in
// Input conditioning ahead of xmpl_flt: accepts wide signed samples over
// valid/ready, keeps 1 of (decim_i+1), saturates to OUT_W bits, buffers in a
// FIFO and paces them out no closer than SPACING cycles apart. The filter has
// no backpressure, so all rate mismatch is absorbed here.
//   clk_i         in   clock
//   reset_n_i     in   asynchronous reset, active low
//   enable_i      in   0 = flush and hold idle
//   decim_i       in   4      keep 1 of (decim_i+1) accepted samples
//   s_valid_i     in   input sample valid
//   s_ready_o     out  input sample ready (registered)
//   s_data_i      in   IN_W   signed input sample
//   xmpl_flt_a_o  out  one-cycle sample strobe to the filter
//   xmpl_flt_b_o  out  OUT_W  sample to the filter, held between strobes
//   level_o       out  FIFO fill level
//   sat_cnt_o     out  CNT_W  clamped-sample count, sticks at all-ones
// ----------------------------------------------------------------------------
module xmpl_flt_in
    import xmpl_dsp_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int OUT_W   = XMPL_SMP_W,
    parameter int DEPTH   = 8,
    parameter int SPACING = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     enable_i,
    input  logic [3:0]               decim_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [IN_W-1:0]          s_data_i,
    output logic                     xmpl_flt_a_o,
    output logic [OUT_W-1:0]         xmpl_flt_b_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_W-1:0]         sat_cnt_o
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int SPC_W = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam logic [SPC_W-1:0] SPC_LOAD = SPC_W'(SPACING - 1);

    logic                            flush;
    logic                            accept;
    logic                            write_sel;
    logic                            push;
    logic                            pop;
    logic [3:0]                      phase;
    logic [SPC_W-1:0]                spacing;
    logic [LVL_W-1:0]                count;
    logic [LVL_W-1:0]                level_nxt;
    logic                            fifo_empty;
    logic [OUT_W-1:0]                head;
    logic signed [XMPL_SAT_IN_W-1:0] s_data_ext;
    sat_res_t                        sat_res;

    assign flush = !enable_i;

    // enable_i also gates accept so that a sample offered during the flush
    // cycle is refused even though the registered ready is still high.
    assign accept = enable_i && s_valid_i && s_ready_o;

    // A phase beyond decim_i can only happen after decim_i shrank on the
    // fly; it is handled as a wrap so the stream resynchronises at once.
    assign write_sel = (phase == 4'd0) || (phase > decim_i);
    assign push      = accept && write_sel;
    assign pop       = enable_i && !fifo_empty && (spacing == '0);

    assign s_data_ext = {{(XMPL_SAT_IN_W - IN_W){s_data_i[IN_W-1]}}, s_data_i};
    assign sat_res    = sat_to_w(s_data_ext);

    xmpl_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (sat_res.value),
        .rdata (head),
        .count (count),
        .empty (fifo_empty)
    );

    assign level_o = count;

    // Mirror of the FIFO's next count, used only to register ready so that
    // ready in any cycle reflects exactly the occupancy seen in that cycle.
    always_comb begin
        level_nxt = count;
        if (flush) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = count + 1'b1;
        end else if (pop && !push) begin
            level_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s_ready_o <= 1'b0;
        end else begin
            s_ready_o <= enable_i && (level_nxt < LVL_W'(DEPTH));
        end
    end

    // Decimation phase: counts accepted samples, 0 marks the kept one.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            phase <= 4'd0;
        end else if (flush) begin
            phase <= 4'd0;
        end else if (accept) begin
            if (write_sel) begin
                phase <= (decim_i == 4'd0) ? 4'd0 : 4'd1;
            end else begin
                phase <= (phase == decim_i) ? 4'd0 : phase + 4'd1;
            end
        end
    end

    // Spacing counter: reloaded on each pop, so the next pop is SPACING
    // cycles later at the earliest.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            spacing <= '0;
        end else if (flush) begin
            spacing <= '0;
        end else if (pop) begin
            spacing <= SPC_LOAD;
        end else if (spacing != '0) begin
            spacing <= spacing - 1'b1;
        end
    end

    // Output strobe and held sample; pop is already low while disabled, and
    // the sample deliberately survives a flush.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            xmpl_flt_a_o <= 1'b0;
            xmpl_flt_b_o <= '0;
        end else begin
            xmpl_flt_a_o <= pop;
            if (pop) begin
                xmpl_flt_b_o <= head;
            end
        end
    end

    // Clamp events are counted only for samples that reach the FIFO.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sat_cnt_o <= '0;
        end else if (push && sat_res.clamped && (sat_cnt_o != '1)) begin
            sat_cnt_o <= sat_cnt_o + 1'b1;
        end
    end

endmodule
